inst_buffer: RTL and testbench
==============================

// Module: inst_buffer
// PURPOSE
//  2-wide fetch/instruction queue between fetch (PC + BTB prediction) and decode/dispatch.
//  Captures up to 2 fetched insts per cycle with their PC and BTB prediction (taken, target).
//  Presents up to 2 oldest entries to dispatch in program order.
//  Drops the wrong-path slot after a predicted-taken branch. Flushes fully on branch recovery.
// PARAMETERS
//  DEPTH  8   entry count; power of 2, >=4
//  XLEN   32  address/inst width; must match `XLEN
// PORTS
//  clk                 in   1         clock, rising edge
//  reset               in   1         asynchronous, active-low reset
//  fetch_valid_i       in   2         slot valid; 2'b10 illegal (slot1 only valid with slot0)
//  fetch_pc_i          in   2xXLEN    PC per slot
//  fetch_inst_i        in   2x32      instruction word per slot
//  predict_en_i        in   2         BTB predicted-taken per slot
//  predict_addr_i      in   2xXLEN    BTB predicted next PC per slot
//  fetch_ready_o       out  1         1 when >=2 free entries; enqueue accepted only if 1
//  branch_recover_i    in   2         any bit set = flush (retire-stage recovery)
//  out_valid_o         out  2         head / head+1 entry valid
//  out_entry_o         out  2xIB_ENTRY  head entries {pc, inst, pred_taken, pred_target}
//  dispatch_ack_i      in   2         dispatch consumed slot; must be contiguous, subset of out_valid_o
//  count_o             out  $clog2(DEPTH)+1  occupied entries (debug/perf)
// BEHAVIOUR
//  Reset (reset==0, async): head=tail=0, count=0; out_valid_o=0, fetch_ready_o=1 (after deassert).
//    out_entry_o=0, count_o=0. Entry payloads need not clear.
//  Storage: circular array, head/tail ptrs $clog2(DEPTH) bits, wrap mod DEPTH. count is separate.
//  Enqueue (posedge, fetch_ready_o==1):
//    n_in = fetch_valid_i[0] + fetch_valid_i[1].
//    Exception: fetch_valid_i[0] && predict_en_i[0] gives n_in=1; slot1 is wrong-path, dropped.
//    Slot0 is written at tail, slot1 at tail+1. tail += n_in.
//  fetch_ready_o = (DEPTH-count) >= 2.
//    Uses the registered count only; same-cycle dequeue frees no space (no comb path ack->ready).
//    If fetch_ready_o==0, inputs are ignored. Fetch must hold its PC; no partial accept.
//  Dequeue (posedge):
//    n_out = dispatch_ack_i[0] ? (dispatch_ack_i[1] ? 2 : 1) : 0. head += n_out.
//    ack[1] without ack[0] is ignored. ack on an invalid slot is ignored, clipped to count.
//  Outputs are combinational reads of head/head+1; out_valid_o = {count>=2, count>=1}.
//  Latency: enqueued entry visible on outputs the cycle after the accepting edge. No bypass.
//  Simultaneous enq+deq: count_next = count + n_in - n_out. Full-to-full and wrap-around are legal.
//  Flush (|branch_recover_i at posedge): head=tail=0, count=0.
//    Same-cycle enqueue and dequeue are discarded (flush wins).
//    out_valid_o=0 the next cycle; fetch_ready_o=1 the next cycle.
//  Empty: out_valid_o=0; acks are ignored. Full: fetch_ready_o=0.
//  Reset asserted mid-operation: state clears immediately (async). Outputs go to reset values
//    the same cycle.
//  Assertions: fetch_valid_i!=2'b10; count<=DEPTH; no ack when the matching out_valid_o is 0.
// STRUCTURE
//  Shared package (sys_defs): typedef struct packed IB_ENTRY
//    {logic [`XLEN-1:0] pc; logic [31:0] inst; logic pred_taken; logic [`XLEN-1:0] pred_target;}
//  Shared package (sys_defs): `IB_DEPTH default 8.
//  Single module, no sub-module. Pointer/count update is one always_comb next-state block.
//    One always_ff with async low reset holds ptrs, count and the entry array.
// TESTING
//  1 Reset, then enq 2 insts pc=0x100/0x104, no pred
//    -> next cycle out_valid=2'b11, pcs 0x100,0x104, count=2.
//  2 Enq pc=0x200 (pred_en[0]=1, target 0x400) + pc=0x204
//    -> only 0x200 stored, count+=1, pred_target=0x400.
//  3 Fill to DEPTH-1=7 with no acks -> fetch_ready_o=0.
//    Then ack 2'b11 with valid enq -> enq ignored, count=5; ready=1 the next cycle.
//  4 Wrap: run 20 cycles enq 2 / ack 2 -> order preserved across ptr wrap; count stays constant.
//  5 count=6, same cycle enq 2 + ack 2 + branch_recover_i=2'b01
//    -> next cycle count=0, out_valid=0, ready=1.
//  6 Drop reset low mid-stream (count=4, between edges) -> out_valid_o=0 immediately.
//    After release, first enq appears at head.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the fetch/instruction-queue slice.
//   `XLEN      address / PC width (default 32)
//   `IB_DEPTH  instruction-buffer entry count (default 8)
//   IB_ENTRY   one queued instruction: PC, instruction word, BTB prediction
//   ack_count  converts a dispatch acknowledge vector into a dequeue count
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IB_DEPTH
`define IB_DEPTH 8
`endif

package sys_defs;

    localparam int IB_XLEN  = `XLEN;
    localparam int IB_DEPTH = `IB_DEPTH;

    typedef struct packed {
        logic [`XLEN-1:0] pc;
        logic [31:0]      inst;
        logic             pred_taken;
        logic [`XLEN-1:0] pred_target;
    } IB_ENTRY;

    // Acks must be contiguous from slot 0; a lone ack[1] is treated as no ack.
    function automatic logic [1:0] ack_count(input logic [1:0] ack);
        logic [1:0] n;
        n = 2'd0;
        if (ack[0]) begin
            n = ack[1] ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/inst_buffer.sv
// 2-wide instruction queue between fetch and decode/dispatch.
// Accepts up to two fetched instructions per cycle (dropping the slot after a
// predicted-taken slot 0), presents the two oldest entries in program order,
// and flushes completely on branch recovery.
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-low reset
//   fetch_valid_i[1:0]     fetch slot valids (slot 1 only with slot 0)
//   fetch_pc_i, fetch_inst_i, predict_en_i, predict_addr_i   per-slot payload
//   fetch_ready_o          at least two free entries; enqueue only when high
//   branch_recover_i[1:0]  any bit set flushes the queue
//   out_valid_o[1:0]       head / head+1 valid
//   out_entry_o[1:0]       head / head+1 entries (zero when not valid)
//   dispatch_ack_i[1:0]    dispatch consumed head (and head+1)
//   count_o                occupied entries
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IB_DEPTH
`define IB_DEPTH 8
`endif

module inst_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = `IB_DEPTH,
    parameter int XLEN  = `XLEN
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    fetch_valid_i,
    input  logic [1:0][XLEN-1:0]          fetch_pc_i,
    input  logic [1:0][31:0]              fetch_inst_i,
    input  logic [1:0]                    predict_en_i,
    input  logic [1:0][XLEN-1:0]          predict_addr_i,
    output logic                          fetch_ready_o,
    input  logic [1:0]                    branch_recover_i,
    output logic [1:0]                    out_valid_o,
    output IB_ENTRY [1:0]                 out_entry_o,
    input  logic [1:0]                    dispatch_ack_i,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    IB_ENTRY       mem_q [DEPTH];
    IB_ENTRY       mem_d [DEPTH];

    logic [1:0]    n_in;
    logic [1:0]    n_out_raw;
    logic [1:0]    n_out;
    logic          flush;
    logic [PW-1:0] head_p1;
    logic [PW-1:0] tail_p1;
    IB_ENTRY       slot0_entry;
    IB_ENTRY       slot1_entry;

    // Ready depends only on the registered count, so a same-cycle dequeue
    // never creates a combinational ack -> ready path.
    assign fetch_ready_o = (count_q <= CW'(DEPTH - 2));
    assign flush         = |branch_recover_i;
    assign head_p1       = head_q + PW'(1);
    assign tail_p1       = tail_q + PW'(1);

    always_comb begin
        slot0_entry.pc          = fetch_pc_i[0];
        slot0_entry.inst        = fetch_inst_i[0];
        slot0_entry.pred_taken  = predict_en_i[0];
        slot0_entry.pred_target = predict_addr_i[0];
        slot1_entry.pc          = fetch_pc_i[1];
        slot1_entry.inst        = fetch_inst_i[1];
        slot1_entry.pred_taken  = predict_en_i[1];
        slot1_entry.pred_target = predict_addr_i[1];
    end

    always_comb begin
        n_in = 2'd0;
        if (fetch_ready_o && fetch_valid_i[0]) begin
            // Slot 1 follows a predicted-taken slot 0 and is wrong-path.
            n_in = (fetch_valid_i[1] && !predict_en_i[0]) ? 2'd2 : 2'd1;
        end

        n_out_raw = ack_count(dispatch_ack_i);
        n_out     = n_out_raw;
        if (CW'(n_out_raw) > count_q) begin
            n_out = count_q[1:0];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (n_in != 2'd0) begin
                mem_d[tail_q] = slot0_entry;
            end
            if (n_in == 2'd2) begin
                mem_d[tail_p1] = slot1_entry;
            end
            tail_d  = tail_q + PW'(n_in);
            head_d  = head_q + PW'(n_out);
            count_d = count_q + CW'(n_in) - CW'(n_out);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        out_valid_o    = {count_q >= CW'(2), count_q >= CW'(1)};
        out_entry_o[0] = out_valid_o[0] ? mem_q[head_q]  : '0;
        out_entry_o[1] = out_valid_o[1] ? mem_q[head_p1] : '0;
        count_o        = count_q;
    end

    a_fetch_valid_legal : assert property (@(posedge clk) disable iff (!reset)
        fetch_valid_i != 2'b10);
    a_count_bound : assert property (@(posedge clk) disable iff (!reset)
        count_q <= CW'(DEPTH));
    a_ack0_valid : assert property (@(posedge clk) disable iff (!reset)
        dispatch_ack_i[0] |-> out_valid_o[0]);
    a_ack1_valid : assert property (@(posedge clk) disable iff (!reset)
        dispatch_ack_i[1] |-> out_valid_o[1]);

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
    import sys_defs::*;

    localparam int DEPTH = IB_DEPTH;
    localparam int XLEN  = IB_XLEN;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0]           fetch_valid;
    logic [1:0][XLEN-1:0] fetch_pc;
    logic [1:0][31:0]     fetch_inst;
    logic [1:0]           predict_en;
    logic [1:0][XLEN-1:0] predict_addr;
    logic                 fetch_ready;
    logic [1:0]           branch_recover;
    logic [1:0]           out_valid;
    IB_ENTRY [1:0]        out_entry;
    logic [1:0]           dispatch_ack;
    logic [CW-1:0]        count;

    IB_ENTRY model_q[$];
    int total = 0;
    int bad   = 0;

    inst_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_valid_i    (fetch_valid),
        .fetch_pc_i       (fetch_pc),
        .fetch_inst_i     (fetch_inst),
        .predict_en_i     (predict_en),
        .predict_addr_i   (predict_addr),
        .fetch_ready_o    (fetch_ready),
        .branch_recover_i (branch_recover),
        .out_valid_o      (out_valid),
        .out_entry_o      (out_entry),
        .dispatch_ack_i   (dispatch_ack),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_valid    = 2'b00;
        fetch_pc       = '0;
        fetch_inst     = '0;
        predict_en     = 2'b00;
        predict_addr   = '0;
        branch_recover = 2'b00;
        dispatch_ack   = 2'b00;
    endtask

    // Slot 1 is always the sequential PC after slot 0; inst word derived from PC.
    task automatic set_fetch(input logic [1:0] fv, input logic [XLEN-1:0] pc0,
                             input logic pred0, input logic [XLEN-1:0] tgt0,
                             input logic pred1, input logic [XLEN-1:0] tgt1);
        fetch_valid     = fv;
        fetch_pc[0]     = pc0;
        fetch_pc[1]     = pc0 + XLEN'(4);
        fetch_inst[0]   = 32'(pc0) ^ 32'hA5A5_0013;
        fetch_inst[1]   = 32'(pc0 + XLEN'(4)) ^ 32'hA5A5_0013;
        predict_en      = {pred1, pred0};
        predict_addr[0] = tgt0;
        predict_addr[1] = tgt1;
    endtask

    function automatic IB_ENTRY mk_entry(input int s);
        IB_ENTRY e;
        e.pc          = fetch_pc[s];
        e.inst        = fetch_inst[s];
        e.pred_taken  = predict_en[s];
        e.pred_target = predict_addr[s];
        return e;
    endfunction

    // Queue-level reference: ready from pre-edge occupancy, flush empties,
    // otherwise pop the acknowledged (clipped) entries and push accepted ones.
    function automatic void model_edge();
        int sz;
        int nout;
        bit rdy;
        sz  = model_q.size();
        rdy = (DEPTH - sz) >= 2;
        if (branch_recover != 2'b00) begin
            model_q.delete();
            return;
        end
        nout = 0;
        if (dispatch_ack[0]) nout = dispatch_ack[1] ? 2 : 1;
        if (nout > sz) nout = sz;
        repeat (nout) void'(model_q.pop_front());
        if (rdy && fetch_valid[0]) begin
            model_q.push_back(mk_entry(0));
            if (fetch_valid[1] && !predict_en[0]) model_q.push_back(mk_entry(1));
        end
    endfunction

    task automatic check(input string tag, input bit chk_ready);
        int sz;
        IB_ENTRY e0;
        IB_ENTRY e1;
        sz = model_q.size();
        e0 = (sz >= 1) ? model_q[0] : '0;
        e1 = (sz >= 2) ? model_q[1] : '0;
        cmp({tag, "_valid"}, 128'(out_valid), 128'({sz >= 2, sz >= 1}));
        cmp({tag, "_count"}, 128'(count), 128'(sz));
        cmp({tag, "_e0"}, 128'(out_entry[0]), 128'(e0));
        cmp({tag, "_e1"}, 128'(out_entry[1]), 128'(e1));
        if (chk_ready) cmp({tag, "_ready"}, 128'(fetch_ready), 128'((DEPTH - sz) >= 2));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag, 1'b1);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        int k;
        logic [1:0] fv;
        idle_inputs();
        reset = 1'b0;
        #1;
        check("reset", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        cmp("ready_after_reset", 128'(fetch_ready), 128'(1));
        @(negedge clk);

        // 1: two sequential insts, no prediction
        set_fetch(2'b11, 'h100, 1'b0, '0, 1'b0, '0);
        cycle("t1");
        cmp("t1_pc0", 128'(out_entry[0].pc), 128'('h100));
        cmp("t1_pc1", 128'(out_entry[1].pc), 128'('h104));
        cmp("t1_count", 128'(count), 128'(2));

        // 2: predicted-taken slot 0 drops slot 1; drain the first two to expose it
        set_fetch(2'b11, 'h200, 1'b1, 'h400, 1'b0, '0);
        dispatch_ack = 2'b11;
        cycle("t2");
        cmp("t2_count", 128'(count), 128'(1));
        cmp("t2_pc", 128'(out_entry[0].pc), 128'('h200));
        cmp("t2_target", 128'(out_entry[0].pred_target), 128'('h400));
        cmp("t2_taken", 128'(out_entry[0].pred_taken), 128'(1));

        // 3: fill to DEPTH-1, then ack 2 while fetch offers 2 -> enqueue ignored
        for (int i = 0; i < 3; i++) begin
            set_fetch(2'b11, XLEN'('h300 + 8 * i), 1'b0, '0, 1'b0, '0);
            cycle("t3_fill");
        end
        cmp("t3_full_count", 128'(count), 128'(DEPTH - 1));
        cmp("t3_not_ready", 128'(fetch_ready), 128'(0));
        set_fetch(2'b11, 'h380, 1'b0, '0, 1'b0, '0);
        dispatch_ack = 2'b11;
        cycle("t3_ack");
        cmp("t3_count_after", 128'(count), 128'(DEPTH - 3));
        cmp("t3_ready_after", 128'(fetch_ready), 128'(1));

        // 4: steady enq 2 / ack 2 across pointer wrap
        for (int i = 0; i < 20; i++) begin
            set_fetch(2'b11, XLEN'('h1000 + 8 * i), 1'b0, '0, 1'b0, '0);
            dispatch_ack = 2'b11;
            cycle("t4_wrap");
        end
        cmp("t4_count_const", 128'(count), 128'(DEPTH - 3));

        // 5: count 6, then enq+ack+recover -> flush wins
        set_fetch(2'b01, 'h2000, 1'b0, '0, 1'b0, '0);
        cycle("t5_pre");
        cmp("t5_count6", 128'(count), 128'(6));
        set_fetch(2'b11, 'h2100, 1'b0, '0, 1'b0, '0);
        dispatch_ack   = 2'b11;
        branch_recover = 2'b01;
        cycle("t5_flush");
        cmp("t5_count0", 128'(count), 128'(0));
        cmp("t5_valid0", 128'(out_valid), 128'(0));
        cmp("t5_ready1", 128'(fetch_ready), 128'(1));

        // 6: async reset between edges with 4 entries queued
        set_fetch(2'b11, 'h3000, 1'b0, '0, 1'b0, '0);
        cycle("t6_a");
        set_fetch(2'b11, 'h3008, 1'b0, '0, 1'b0, '0);
        cycle("t6_b");
        cmp("t6_count4", 128'(count), 128'(4));
        #2;
        reset = 1'b0;
        model_q.delete();
        #1;
        check("t6_rst", 1'b0);
        cmp("t6_valid_now", 128'(out_valid), 128'(0));
        #1;
        reset = 1'b1;
        cycle("t6_idle");
        set_fetch(2'b01, 'h900, 1'b0, '0, 1'b0, '0);
        cycle("t6_first");
        cmp("t6_head_pc", 128'(out_entry[0].pc), 128'('h900));

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            k  = int'($urandom_range(0, 2));
            fv = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            set_fetch(fv, XLEN'({$urandom_range(0, 32'hFFFF), 2'b00}),
                      ($urandom_range(0, 3) == 0), XLEN'({$urandom, 2'b00}),
                      ($urandom_range(0, 3) == 0), XLEN'({$urandom, 2'b00}));
            fetch_inst[1] = $urandom;
            k = int'($urandom_range(0, 3));
            if (k > model_q.size()) k = model_q.size();
            if (k == 3) k = 2;
            dispatch_ack = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
            if (model_q.size() >= 2 && $urandom_range(0, 9) == 0) dispatch_ack = 2'b10;
            if ($urandom_range(0, 24) == 0) branch_recover = 2'($urandom_range(1, 3));
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
